// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding, header length and instruction word width.
// Build option: IMEM_LOADER_CKSUM_EN adds the trailing checksum state.
package loader_pkg;

  localparam int HDR_LEN = 2;                 // header is a 2-byte word count
  localparam int WORD_W  = 16;                // instruction word width
  localparam int BYTE_W  = WORD_W / HDR_LEN;  // host stream is byte-wide

  typedef enum logic [2:0] {
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA_HI,
    ST_DATA_LO,
`ifdef IMEM_LOADER_CKSUM_EN
    ST_CKSUM,
`endif
    ST_FLUSH,
    ST_RUN,
    ST_ERR
  } state_e;

endpackage

// File: rtl/word_assembler.sv
// Byte-pair to word assembler: holds the high byte and presents
// {high, current byte} so the low-byte accept sees the full word.
module word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              hi_en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o
);

  logic [BYTE_W-1:0] hi_q;

  // Capture the high byte of a pair when it is accepted.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      hi_q <= '0;
    end else if (hi_en_i) begin
      hi_q <= byte_i;
    end
  end

  assign word_o = {hi_q, byte_i};

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: receives a counted byte stream, writes 16-bit
// words into instruction memory from address 0 and holds the CPU in reset
// until the image is committed.
// Build option: IMEM_LOADER_CKSUM_EN enables a trailing XOR checksum byte.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // Largest legal word count: exactly fills the memory.
  localparam logic [WORD_W:0] MAX_WORDS = (WORD_W + 1)'(1) << ADDR_W;

`ifdef IMEM_LOADER_CKSUM_EN
  localparam state_e AFTER_DATA = ST_CKSUM;
`else
  localparam state_e AFTER_DATA = ST_FLUSH;
`endif

  state_e            state_q, state_d;
  logic              accept;
  logic [WORD_W-1:0] word;
  logic [WORD_W:0]   hdr_n;
  logic [ADDR_W:0]   idx_q;    // next word index; one extra bit so a full image never wraps
  logic [ADDR_W:0]   cnt_q;    // word count from the header
  logic              last_word;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [BYTE_W-1:0] cksum_q;
`endif

  assign accept    = in_valid && in_ready;
  assign hdr_n     = {1'b0, word};
  assign last_word = (idx_q + (ADDR_W + 1)'(1)) == cnt_q;

  word_assembler u_word_assembler (
    .clk     (clk),
    .reset   (reset),
    .hi_en_i (accept && (state_q == ST_HDR_HI || state_q == ST_DATA_HI)),
    .byte_i  (in_byte),
    .word_o  (word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_HDR_HI;
    else       state_q <= state_d;
  end

  // Next-state logic: advance only on accepted bytes, except FLUSH.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      ST_HDR_HI:  if (accept) state_d = ST_HDR_LO;
      ST_HDR_LO:
        if (accept) begin
          if (hdr_n > MAX_WORDS) state_d = ST_ERR;
          else if (hdr_n == '0)  state_d = AFTER_DATA;
          else                   state_d = ST_DATA_HI;
        end
      ST_DATA_HI: if (accept) state_d = ST_DATA_LO;
      ST_DATA_LO: if (accept) state_d = last_word ? AFTER_DATA : ST_DATA_HI;
`ifdef IMEM_LOADER_CKSUM_EN
      ST_CKSUM:   if (accept) state_d = (in_byte == cksum_q) ? ST_FLUSH : ST_ERR;
`endif
      ST_FLUSH:   state_d = ST_RUN;
      default:    state_d = state_q;  // RUN and ERR are terminal
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state_q)
      ST_HDR_HI, ST_HDR_LO, ST_DATA_HI, ST_DATA_LO: in_ready = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
      ST_CKSUM: in_ready = 1'b1;
`endif
      ST_RUN: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      ST_ERR:  error = 1'b1;
      default: ;
    endcase
  end

  // Word counter, write port registers and checksum accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      if (accept && state_q == ST_HDR_LO) begin
        cnt_q <= hdr_n[ADDR_W:0];
      end
      if (accept && state_q == ST_DATA_LO) begin
        we_q    <= 1'b1;
        addr_q  <= idx_q[ADDR_W-1:0];
        wdata_q <= word;
        idx_q   <= idx_q + (ADDR_W + 1)'(1);
      end
`ifdef IMEM_LOADER_CKSUM_EN
      if (accept && state_q != ST_CKSUM) begin
        cksum_q <= cksum_q ^ in_byte;
      end
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule
